// File: rtl/order_hash_table_pkg.sv
// Shared types and the reference-number hash for the order hash table.
package order_hash_table_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_DEL  = 2'd1,
    OP_EXEC = 2'd2,
    OP_RSVD = 2'd3
  } opType;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LIVE  = 2'd1,
    ST_TOMB  = 2'd2
  } entryStateType;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CMP,
    S_WRITE
  } fsmStateType;

  typedef struct packed {
    entryStateType state;
    logic [63:0]   refNum;
    logic [15:0]   locate;
    logic [31:0]   price;
    logic [31:0]   shares;
    logic          buySell;
  } orderEntryType;

  localparam int HASH_MAX_BITS = 16;

  // Bit i of the reference lands in hash bit (i mod addrBits): an LSB-first
  // XOR-fold into addrBits-wide chunks with the top chunk zero-padded.
  function automatic logic [HASH_MAX_BITS-1:0] hashRef(input logic [63:0] refNum,
                                                      input int addrBits);
    logic [HASH_MAX_BITS-1:0] h;
    int pos;
    h   = '0;
    pos = 0;
    for (int i = 0; i < 64; i++) begin
      h[pos[3:0]] = h[pos[3:0]] ^ refNum[i];
      pos = (pos == addrBits - 1) ? 0 : pos + 1;
    end
    return h;
  endfunction

endpackage

// File: rtl/order_hash_table_ram.sv
// Single-port entry store with registered address and registered read data.
module order_entry_ram
  import order_hash_table_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clkIn,
  input  logic                 weIn,
  input  logic [ADDR_BITS-1:0] addrIn,
  input  orderEntryType        wrDataIn,
  output orderEntryType        rdDataOut
);

  (* ram_style = "block" *) orderEntryType mem [DEPTH];
  logic [ADDR_BITS-1:0] addrQ;

  // NOTE: the array and its read pipeline have no reset; a reset port would
  // stop the tools mapping this onto block RAM. The owner sweeps it instead.
  always_ff @(posedge clkIn) begin
    if (weIn) mem[addrIn] <= wrDataIn;
    addrQ     <= addrIn;
    rdDataOut <= mem[addrQ];
  end

endmodule

// File: rtl/order_hash_table.sv
// Order-reference hash table: linear probing with tombstones, one command in flight.
module order_hash_table
  import order_hash_table_pkg::*;
#(
  parameter int ORDER_MAP_DEPTH = 4096,
  parameter int MAX_PROBES      = 8
) (
  input  logic                               clkIn,
  input  logic                               rstIn,
  input  logic                               cmdValidIn,
  output logic                               cmdReadyOut,
  input  logic [1:0]                         cmdOpIn,
  input  logic [63:0]                        refNumIn,
  input  logic [15:0]                        locateIn,
  input  logic [31:0]                        priceIn,
  input  logic [31:0]                        sharesIn,
  input  logic                               buySellIn,
  output logic                               rspValidOut,
  output logic [1:0]                         rspOpOut,
  output logic                               rspHitOut,
  output logic [15:0]                        locateOut,
  output logic [31:0]                        priceOut,
  output logic                               buySellOut,
  output logic [31:0]                        sharesOut,
  output logic                               removedOut,
  output logic [$clog2(ORDER_MAP_DEPTH):0]   countOut
);

  localparam int ADDR_BITS  = $clog2(ORDER_MAP_DEPTH);
  localparam int PROBE_BITS = (MAX_PROBES > 1) ? $clog2(MAX_PROBES) : 1;

  typedef logic [ADDR_BITS-1:0]  addrType;
  typedef logic [PROBE_BITS-1:0] probeType;

  localparam addrType  LAST_ADDR  = addrType'(ORDER_MAP_DEPTH - 1);
  localparam probeType LAST_PROBE = probeType'(MAX_PROBES - 1);

  fsmStateType   state;
  addrType       initAddr;
  addrType       probeAddr;
  probeType      probeCnt;

  opType         cmdOp;
  logic [63:0]   cmdRef;
  logic [15:0]   cmdLocate;
  logic [31:0]   cmdPrice;
  logic [31:0]   cmdShares;
  logic          cmdBuySell;

  logic          pendWr;
  orderEntryType pendEntry;
  logic          pendHit;
  logic          pendRemoved;
  logic          pendInc;
  logic          pendDec;
  logic [15:0]   pendLocate;
  logic [31:0]   pendPrice;
  logic [31:0]   pendShares;
  logic          pendBuySell;

  logic          ramWe;
  addrType       ramAddr;
  orderEntryType ramWrData;
  orderEntryType ramRdData;

  logic isLive;
  logic isEmpty;
  logic refMatch;
  logic lastProbe;

  assign isLive    = (ramRdData.state == ST_LIVE);
  assign isEmpty   = (ramRdData.state == ST_EMPTY);
  assign refMatch  = (ramRdData.refNum == cmdRef);
  assign lastProbe = (probeCnt == LAST_PROBE);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    ramWe           = 1'b0;
    ramAddr         = probeAddr;
    ramWrData       = pendEntry;
    if (!rstIn) begin
      case (state)
        S_INIT: begin
          ramWe           = 1'b1;
          ramAddr         = initAddr;
          ramWrData       = '0;
          ramWrData.state = ST_EMPTY;
        end
        S_WRITE: ramWe = pendWr;
        default: ;
      endcase
    end
  end

  order_entry_ram #(
    .DEPTH     (ORDER_MAP_DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) entryRam (
    .clkIn     (clkIn),
    .weIn      (ramWe),
    .addrIn    (ramAddr),
    .wrDataIn  (ramWrData),
    .rdDataOut (ramRdData)
  );

  // NOTE: only control state and visible outputs are reset; the command and
  // pending-result registers are always loaded before they are read.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state       <= S_INIT;
      initAddr    <= '0;
      cmdReadyOut <= 1'b0;
      rspValidOut <= 1'b0;
      rspOpOut    <= '0;
      rspHitOut   <= 1'b0;
      locateOut   <= '0;
      priceOut    <= '0;
      buySellOut  <= 1'b0;
      sharesOut   <= '0;
      removedOut  <= 1'b0;
      countOut    <= '0;
    end else begin
      rspValidOut <= 1'b0;
      case (state)
        S_INIT: begin
          initAddr <= initAddr + 1'b1;
          if (initAddr == LAST_ADDR) begin
            state       <= S_IDLE;
            cmdReadyOut <= 1'b1;
          end
        end

        S_IDLE: begin
          if (cmdValidIn) begin
            cmdOp       <= opType'(cmdOpIn);
            cmdRef      <= refNumIn;
            cmdLocate   <= locateIn;
            cmdPrice    <= priceIn;
            cmdShares   <= sharesIn;
            cmdBuySell  <= buySellIn;
            probeAddr   <= addrType'(hashRef(refNumIn, ADDR_BITS));
            probeCnt    <= '0;
            cmdReadyOut <= 1'b0;
            state       <= S_READ;
          end
        end

        S_READ: state <= S_WAIT;
        S_WAIT: state <= S_CMP;

        S_CMP: begin
          pendWr      <= 1'b0;
          pendHit     <= 1'b0;
          pendRemoved <= 1'b0;
          pendInc     <= 1'b0;
          pendDec     <= 1'b0;
          pendLocate  <= '0;
          pendPrice   <= '0;
          pendShares  <= '0;
          pendBuySell <= 1'b0;
          state       <= S_WRITE;
          case (cmdOp)
            OP_ADD: begin
              pendLocate  <= cmdLocate;
              pendPrice   <= cmdPrice;
              pendShares  <= cmdShares;
              pendBuySell <= cmdBuySell;
              if (!isLive) begin
                pendWr    <= 1'b1;
                pendHit   <= 1'b1;
                pendInc   <= 1'b1;
                pendEntry <= '{state: ST_LIVE, refNum: cmdRef, locate: cmdLocate,
                               price: cmdPrice, shares: cmdShares, buySell: cmdBuySell};
              end else if (!lastProbe) begin
                state     <= S_READ;
                probeAddr <= probeAddr + 1'b1;
                probeCnt  <= probeCnt + 1'b1;
              end
            end
            OP_DEL, OP_EXEC: begin
              if (isLive && refMatch) begin
                pendWr      <= 1'b1;
                pendHit     <= 1'b1;
                pendLocate  <= ramRdData.locate;
                pendPrice   <= ramRdData.price;
                pendBuySell <= ramRdData.buySell;
                pendEntry   <= ramRdData;
                // A fill that covers the remaining shares retires the order like a delete.
                if (cmdOp == OP_EXEC && cmdShares < ramRdData.shares) begin
                  pendEntry.shares <= ramRdData.shares - cmdShares;
                  pendShares       <= cmdShares;
                end else begin
                  pendEntry.state <= ST_TOMB;
                  pendShares      <= ramRdData.shares;
                  pendRemoved     <= 1'b1;
                  pendDec         <= 1'b1;
                end
              end else if (!isEmpty && !lastProbe) begin
                state     <= S_READ;
                probeAddr <= probeAddr + 1'b1;
                probeCnt  <= probeCnt + 1'b1;
              end
            end
            default: ;
          endcase
        end

        S_WRITE: begin
          rspValidOut <= 1'b1;
          rspOpOut    <= cmdOp;
          rspHitOut   <= pendHit;
          locateOut   <= pendLocate;
          priceOut    <= pendPrice;
          buySellOut  <= pendBuySell;
          sharesOut   <= pendShares;
          removedOut  <= pendRemoved;
          if (pendInc)      countOut <= countOut + 1'b1;
          else if (pendDec) countOut <= countOut - 1'b1;
          cmdReadyOut <= 1'b1;
          state       <= S_IDLE;
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_order_hash_table.sv
// Self-checking bench: directed scenarios plus random traffic against a slot-level model.
module tb_order_hash_table;

  localparam int DEPTH = 16;
  localparam int MAXP  = 3;
  localparam int AB    = 4;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b0;
  logic        cmdValidIn = 1'b0;
  logic        cmdReadyOut;
  logic [1:0]  cmdOpIn = '0;
  logic [63:0] refNumIn = '0;
  logic [15:0] locateIn = '0;
  logic [31:0] priceIn = '0;
  logic [31:0] sharesIn = '0;
  logic        buySellIn = 1'b0;
  logic        rspValidOut;
  logic [1:0]  rspOpOut;
  logic        rspHitOut;
  logic [15:0] locateOut;
  logic [31:0] priceOut;
  logic        buySellOut;
  logic [31:0] sharesOut;
  logic        removedOut;
  logic [AB:0] countOut;

  order_hash_table #(.ORDER_MAP_DEPTH(DEPTH), .MAX_PROBES(MAXP)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .cmdValidIn(cmdValidIn), .cmdReadyOut(cmdReadyOut),
    .cmdOpIn(cmdOpIn), .refNumIn(refNumIn), .locateIn(locateIn), .priceIn(priceIn),
    .sharesIn(sharesIn), .buySellIn(buySellIn), .rspValidOut(rspValidOut),
    .rspOpOut(rspOpOut), .rspHitOut(rspHitOut), .locateOut(locateOut),
    .priceOut(priceOut), .buySellOut(buySellOut), .sharesOut(sharesOut),
    .removedOut(removedOut), .countOut(countOut)
  );

  always #5 clkIn = ~clkIn;

  int checks = 0;
  int errors = 0;

  // Model: slot 0=empty 1=live 2=tomb
  int          mState [DEPTH];
  logic [63:0] mRef   [DEPTH];
  logic [15:0] mLoc   [DEPTH];
  logic [31:0] mPrice [DEPTH];
  logic [31:0] mShares[DEPTH];
  logic        mSide  [DEPTH];
  int          mCount;

  int          expLat;
  logic        expHit, expRemoved, expSide;
  logic [15:0] expLoc;
  logic [31:0] expPrice, expShares;

  int          obsLat, obsCount;
  logic        obsHit, obsRemoved, obsSide, obsPulse;
  logic [1:0]  obsOp;
  logic [15:0] obsLoc;
  logic [31:0] obsPrice, obsShares;

  function automatic int refHash(input logic [63:0] r);
    int h = 0;
    for (int c = 0; c < 64; c += AB) h ^= int'((r >> c) & 64'(DEPTH - 1));
    return h;
  endfunction

  function automatic bit modelLive(input logic [63:0] r);
    for (int s = 0; s < DEPTH; s++) if (mState[s] == 1 && mRef[s] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelClear();
    for (int s = 0; s < DEPTH; s++) mState[s] = 0;
    mCount = 0;
  endtask

  task automatic modelCmd(input int op, input logic [63:0] r, input logic [15:0] loc,
                          input logic [31:0] pr, input logic [31:0] sh, input logic side);
    int h, s, probes;
    h = refHash(r);
    probes = 1;
    expHit = 0; expRemoved = 0; expLoc = '0; expPrice = '0; expShares = '0; expSide = 0;
    if (op == 0) begin
      expLoc = loc; expPrice = pr; expShares = sh; expSide = side;
      probes = MAXP;
      for (int i = 0; i < MAXP; i++) begin
        s = (h + i) % DEPTH;
        if (mState[s] != 1) begin
          mState[s] = 1; mRef[s] = r; mLoc[s] = loc; mPrice[s] = pr;
          mShares[s] = sh; mSide[s] = side;
          mCount++; expHit = 1; probes = i + 1;
          break;
        end
      end
    end else if (op == 1 || op == 2) begin
      probes = MAXP;
      for (int i = 0; i < MAXP; i++) begin
        s = (h + i) % DEPTH;
        if (mState[s] == 0) begin probes = i + 1; break; end
        if (mState[s] == 1 && mRef[s] == r) begin
          probes = i + 1; expHit = 1;
          expLoc = mLoc[s]; expPrice = mPrice[s]; expSide = mSide[s];
          if (op == 2 && sh < mShares[s]) begin
            mShares[s] = mShares[s] - sh; expShares = sh;
          end else begin
            expShares = mShares[s]; expRemoved = 1; mState[s] = 2; mCount--;
          end
          break;
        end
      end
    end
    expLat = 4 + 3 * (probes - 1);
  endtask

  task automatic applyReset();
    @(negedge clkIn);
    rstIn = 1'b1;
    @(posedge clkIn);
    #1 rstIn = 1'b0;
    modelClear();
  endtask

  task automatic waitInit(output int n, output bit sawRsp);
    n = 0; sawRsp = 0;
    for (int c = 0; c < 4 * DEPTH; c++) begin
      @(negedge clkIn);
      if (rspValidOut) sawRsp = 1;
      if (cmdReadyOut) break;
      n++;
    end
  endtask

  task automatic resetAndInit();
    int n;
    bit saw;
    applyReset();
    waitInit(n, saw);
  endtask

  task automatic runCmd(input int op, input logic [63:0] r, input logic [15:0] loc,
                        input logic [31:0] pr, input logic [31:0] sh, input logic side);
    int n = 0;
    @(negedge clkIn);
    while (!cmdReadyOut) begin
      n++;
      if (n > 200) begin
        errors++; checks++;
        $display("FAIL cmd_ready_timeout: got 0 expected 1");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "cmdReadyOut never returned");
      end
      @(negedge clkIn);
    end
    cmdValidIn = 1'b1; cmdOpIn = 2'(op); refNumIn = r; locateIn = loc;
    priceIn = pr; sharesIn = sh; buySellIn = side;
    @(posedge clkIn);
    #1;
    cmdValidIn = 1'b0;
    refNumIn = {$urandom, $urandom}; sharesIn = $urandom; priceIn = $urandom;
    locateIn = 16'($urandom); buySellIn = 1'($urandom);
    obsLat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clkIn);
      #1;
      if (rspValidOut) begin obsLat = c; break; end
    end
    obsHit = rspHitOut; obsOp = rspOpOut; obsRemoved = removedOut; obsLoc = locateOut;
    obsPrice = priceOut; obsShares = sharesOut; obsSide = buySellOut;
    obsCount = int'(countOut);
    @(posedge clkIn);
    #1 obsPulse = !rspValidOut;
  endtask

  task automatic test_reset();
    int n;
    bit saw;
    applyReset();
    checks++;
    if (cmdReadyOut !== 1'b0 || rspValidOut !== 1'b0 || countOut !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b count=%0d expected 0 0 0",
               cmdReadyOut, rspValidOut, countOut);
    end
    checks++;
    if ({rspOpOut, rspHitOut, locateOut, priceOut, buySellOut, sharesOut, removedOut} !== '0) begin
      errors++;
      $display("FAIL reset_rsp_fields: got op=%0d hit=%b loc=%0d price=%0d shares=%0d expected all 0",
               rspOpOut, rspHitOut, locateOut, priceOut, sharesOut);
    end
    waitInit(n, saw);
    checks++;
    if (n !== DEPTH) begin
      errors++; $display("FAIL init_cycles: got %0d expected %0d", n, DEPTH);
    end
  endtask

  task automatic test_add_exec();
    resetAndInit();
    runCmd(0, 64'h1234, 16'd7, 32'd100, 32'd50, 1'b1);
    checks++;
    if (obsLat !== 4 || obsHit !== 1'b1 || obsCount !== 1) begin
      errors++;
      $display("FAIL add_first: got lat=%0d hit=%b count=%0d expected 4 1 1", obsLat, obsHit, obsCount);
    end
    checks++;
    if (obsPulse !== 1'b1) begin
      errors++; $display("FAIL rsp_pulse: got extra cycles expected one-cycle pulse");
    end
    runCmd(2, 64'h1234, 16'd0, 32'd0, 32'd20, 1'b0);
    checks++;
    if (obsShares !== 32'd20 || obsRemoved !== 1'b0 || obsHit !== 1'b1 || obsOp !== 2'd2) begin
      errors++;
      $display("FAIL exec_partial: got shares=%0d removed=%b hit=%b op=%0d expected 20 0 1 2",
               obsShares, obsRemoved, obsHit, obsOp);
    end
    checks++;
    if (obsPrice !== 32'd100 || obsLoc !== 16'd7 || obsSide !== 1'b1) begin
      errors++;
      $display("FAIL exec_fields: got price=%0d loc=%0d side=%b expected 100 7 1",
               obsPrice, obsLoc, obsSide);
    end
    runCmd(2, 64'h1234, 16'd0, 32'd0, 32'd40, 1'b0);
    checks++;
    if (obsShares !== 32'd30 || obsRemoved !== 1'b1 || obsCount !== 0) begin
      errors++;
      $display("FAIL exec_overfill: got shares=%0d removed=%b count=%0d expected 30 1 0",
               obsShares, obsRemoved, obsCount);
    end
  endtask

  task automatic test_collisions();
    resetAndInit();
    runCmd(0, 64'h5, 16'd1, 32'd10, 32'd11, 1'b0);
    runCmd(0, 64'h50, 16'd2, 32'd20, 32'd22, 1'b0);
    checks++;
    if (obsLat !== 7) begin errors++; $display("FAIL add_probe2_lat: got %0d expected 7", obsLat); end
    runCmd(0, 64'h500, 16'd3, 32'd30, 32'd33, 1'b1);
    checks++;
    if (obsLat !== 10 || obsCount !== 3) begin
      errors++; $display("FAIL add_probe3: got lat=%0d count=%0d expected 10 3", obsLat, obsCount);
    end
    runCmd(1, 64'h50, 16'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if (obsLat !== 7 || obsHit !== 1'b1 || obsShares !== 32'd22) begin
      errors++;
      $display("FAIL del_middle: got lat=%0d hit=%b shares=%0d expected 7 1 22", obsLat, obsHit, obsShares);
    end
    runCmd(1, 64'h500, 16'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if (obsLat !== 10 || obsHit !== 1'b1 || obsRemoved !== 1'b1 || obsPrice !== 32'd30) begin
      errors++;
      $display("FAIL del_past_tomb: got lat=%0d hit=%b removed=%b price=%0d expected 10 1 1 30",
               obsLat, obsHit, obsRemoved, obsPrice);
    end
    runCmd(0, 64'h5000, 16'd4, 32'd40, 32'd44, 1'b0);
    checks++;
    if (obsLat !== 7 || obsHit !== 1'b1 || obsCount !== 2) begin
      errors++;
      $display("FAIL add_reuse_tomb: got lat=%0d hit=%b count=%0d expected 7 1 2", obsLat, obsHit, obsCount);
    end
  endtask

  task automatic test_full();
    resetAndInit();
    runCmd(0, 64'h9, 16'd1, 32'd1, 32'd1, 1'b0);
    runCmd(0, 64'h90, 16'd1, 32'd1, 32'd1, 1'b0);
    runCmd(0, 64'h900, 16'd1, 32'd1, 32'd1, 1'b0);
    runCmd(0, 64'h9000, 16'd5, 32'd55, 32'd66, 1'b1);
    checks++;
    if (obsHit !== 1'b0 || obsCount !== 3 || obsLat !== 10) begin
      errors++;
      $display("FAIL add_full: got hit=%b count=%0d lat=%0d expected 0 3 10", obsHit, obsCount, obsLat);
    end
    checks++;
    if (obsShares !== 32'd66 || obsPrice !== 32'd55) begin
      errors++;
      $display("FAIL add_full_echo: got shares=%0d price=%0d expected 66 55", obsShares, obsPrice);
    end
    runCmd(1, 64'h9000, 16'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if (obsHit !== 1'b0 || obsLat !== 10) begin
      errors++; $display("FAIL del_miss_full: got hit=%b lat=%0d expected 0 10", obsHit, obsLat);
    end
  endtask

  task automatic test_miss_wrap();
    resetAndInit();
    runCmd(1, 64'h77, 16'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if (obsHit !== 1'b0 || obsLat !== 4 || obsRemoved !== 1'b0) begin
      errors++;
      $display("FAIL del_empty_miss: got hit=%b lat=%0d removed=%b expected 0 4 0", obsHit, obsLat, obsRemoved);
    end
    runCmd(0, 64'hF, 16'd1, 32'd1, 32'd5, 1'b0);
    runCmd(0, 64'hF0, 16'd2, 32'd2, 32'd6, 1'b0);
    runCmd(0, 64'hF00, 16'd3, 32'd3, 32'd10, 1'b1);
    runCmd(1, 64'hF0, 16'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if (obsHit !== 1'b1 || obsLat !== 7 || obsShares !== 32'd6) begin
      errors++;
      $display("FAIL wrap_del: got hit=%b lat=%0d shares=%0d expected 1 7 6", obsHit, obsLat, obsShares);
    end
    runCmd(2, 64'hF00, 16'd0, 32'd0, 32'd999, 1'b0);
    checks++;
    if (obsHit !== 1'b1 || obsLat !== 10 || obsShares !== 32'd10 || obsRemoved !== 1'b1) begin
      errors++;
      $display("FAIL wrap_exec_clamp: got hit=%b lat=%0d shares=%0d removed=%b expected 1 10 10 1",
               obsHit, obsLat, obsShares, obsRemoved);
    end
    runCmd(3, 64'hF, 16'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if (obsHit !== 1'b0 || obsLat !== 4 || obsOp !== 2'd3 || obsCount !== 1) begin
      errors++;
      $display("FAIL reserved_op: got hit=%b lat=%0d op=%0d count=%0d expected 0 4 3 1",
               obsHit, obsLat, obsOp, obsCount);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit saw1, saw2;
    resetAndInit();
    runCmd(0, 64'hABC, 16'd9, 32'd9, 32'd9, 1'b0);
    @(negedge clkIn);
    cmdValidIn = 1'b1; cmdOpIn = 2'd0; refNumIn = 64'hDEF; sharesIn = 32'd3;
    @(posedge clkIn);
    #1 cmdValidIn = 1'b0;
    @(posedge clkIn);
    #1 saw1 = rspValidOut;
    @(negedge clkIn);
    rstIn = 1'b1;
    @(posedge clkIn);
    #1 rstIn = 1'b0;
    if (rspValidOut) saw1 = 1'b1;
    modelClear();
    waitInit(n, saw2);
    checks++;
    if ((saw1 | saw2) !== 1'b0 || n !== DEPTH || countOut !== '0) begin
      errors++;
      $display("FAIL mid_reset: got rsp=%b init=%0d count=%0d expected 0 %0d 0",
               saw1 | saw2, n, countOut, DEPTH);
    end
    runCmd(1, 64'hABC, 16'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if (obsHit !== 1'b0 || obsLat !== 4) begin
      errors++; $display("FAIL mid_reset_gone: got hit=%b lat=%0d expected 0 4", obsHit, obsLat);
    end
  endtask

  task automatic test_random();
    logic [63:0] pool[24];
    int op, idx;
    logic [31:0] sh, pr;
    logic [15:0] loc;
    logic side;
    resetAndInit();
    for (int i = 0; i < 24; i++) begin
      pool[i] = (i < 8) ? 64'($urandom_range(255, 1)) : {$urandom, $urandom};
      if (pool[i] == '0) pool[i] = 64'(i + 1);
    end
    for (int k = 0; k < 200; k++) begin
      idx = $urandom_range(23, 0);
      op  = $urandom_range(99, 0);
      op  = (op < 40) ? 0 : (op < 65) ? 1 : (op < 95) ? 2 : 3;
      if (op == 0 && modelLive(pool[idx])) op = 1;
      sh  = (op == 2) ? 32'($urandom_range(120, 1)) : 32'($urandom_range(100, 1));
      pr  = $urandom; loc = 16'($urandom); side = 1'($urandom);
      runCmd(op, pool[idx], loc, pr, sh, side);
      modelCmd(op, pool[idx], loc, pr, sh, side);
      checks++;
      if (obsLat !== expLat || obsHit !== expHit || obsOp !== 2'(op)) begin
        errors++;
        $display("FAIL rnd_status[%0d]: got lat=%0d hit=%b op=%0d expected %0d %b %0d",
                 k, obsLat, obsHit, obsOp, expLat, expHit, op);
      end
      checks++;
      if (obsRemoved !== expRemoved || obsCount !== mCount) begin
        errors++;
        $display("FAIL rnd_count[%0d]: got removed=%b count=%0d expected %b %0d",
                 k, obsRemoved, obsCount, expRemoved, mCount);
      end
      if (expHit || op == 0) begin
        checks++;
        if (obsShares !== expShares || obsPrice !== expPrice || obsLoc !== expLoc || obsSide !== expSide) begin
          errors++;
          $display("FAIL rnd_fields[%0d]: got sh=%0d pr=%0d loc=%0d side=%b expected %0d %0d %0d %b",
                   k, obsShares, obsPrice, obsLoc, obsSide, expShares, expPrice, expLoc, expSide);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_exec();
    test_collisions();
    test_full();
    test_miss_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
